// File: rtl/noc_pkg.sv
// Shared constants and helpers for the NoC node interface: default flit width,
// error flag bit positions and the credit counter width calculation.
package noc_pkg;

  localparam int FLIT_W_DEFAULT = 20;

  localparam int ERR_EJ_OVF     = 0;
  localparam int ERR_CREDIT_OVF = 1;

  // Wide enough to hold every value from 0 up to and including the credit maximum.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/noc_node_interface_if.sv
// PE-side and router-side handshake bundle of the node interface.
// The slave modport is the NI view; the master modport is the PE/router view.
interface noc_node_interface_if
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEFAULT
) ();

  logic [FLIT_W-1:0] pe_tx_data;
  logic              pe_tx_valid;
  logic              pe_tx_ready;

  logic [FLIT_W-1:0] pe_rx_data;
  logic              pe_rx_valid;
  logic              pe_rx_ready;

  logic [FLIT_W-1:0] rt_inj_data;
  logic              rt_inj_valid;
  logic              rt_inj_credit;

  logic [FLIT_W-1:0] rt_ej_data;
  logic              rt_ej_valid;
  logic              rt_ej_credit;

  modport slave (
    input  pe_tx_data, pe_tx_valid, pe_rx_ready,
    input  rt_inj_credit, rt_ej_data, rt_ej_valid,
    output pe_tx_ready, pe_rx_data, pe_rx_valid,
    output rt_inj_data, rt_inj_valid, rt_ej_credit
  );

  modport master (
    output pe_tx_data, pe_tx_valid, pe_rx_ready,
    output rt_inj_credit, rt_ej_data, rt_ej_valid,
    input  pe_tx_ready, pe_rx_data, pe_rx_valid,
    input  rt_inj_data, rt_inj_valid, rt_ej_credit
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// First-word fall-through synchronous FIFO using wrap pointers with an extra MSB.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module noc_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty pointers hide whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_node_interface.sv
// Network interface between a PE and the router local port: buffered, credit-metered
// injection, buffered ejection with per-flit credit return, traffic counters, sticky errors.
module noc_node_interface
  import noc_pkg::*;
#(
  parameter int FLIT_W     = FLIT_W_DEFAULT,
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 4,
  parameter int RT_CREDITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  noc_node_interface_if.slave  bus,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic [1:0]           err
);

  localparam int             CW         = credit_width(RT_CREDITS);
  localparam logic [CW-1:0]  CREDIT_MAX = CW'(RT_CREDITS);

  logic [CW-1:0]     credits;
  logic [FLIT_W-1:0] inj_dout;
  logic [FLIT_W-1:0] ej_dout;
  logic              inj_full;
  logic              inj_empty;
  logic              ej_full;
  logic              ej_empty;
  logic              send;
  logic              ej_pop;
  logic              ej_accept;
  logic              inj_valid;
  logic [FLIT_W-1:0] inj_data;
  logic              ej_credit;

  assign send      = !inj_empty && (credits != '0);
  assign ej_pop    = !ej_empty && bus.pe_rx_ready;
  assign ej_accept = bus.rt_ej_valid && (!ej_full || ej_pop);

  assign bus.pe_tx_ready  = !inj_full;
  assign bus.pe_rx_valid  = !ej_empty;
  assign bus.pe_rx_data   = ej_dout;
  assign bus.rt_inj_valid = inj_valid;
  assign bus.rt_inj_data  = inj_data;
  assign bus.rt_ej_credit = ej_credit;

  noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rst_n (RST),
    .push  (bus.pe_tx_valid && !inj_full),
    .pop   (send),
    .din   (bus.pe_tx_data),
    .dout  (inj_dout),
    .full  (inj_full),
    .empty (inj_empty)
  );

  noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk   (clk),
    .rst_n (RST),
    .push  (bus.rt_ej_valid),
    .pop   (ej_pop),
    .din   (bus.rt_ej_data),
    .dout  (ej_dout),
    .full  (ej_full),
    .empty (ej_empty)
  );

  // A credit arriving at the maximum is bogus: flag it and leave the count alone.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      credits   <= CREDIT_MAX;
      inj_valid <= 1'b0;
      inj_data  <= '0;
      ej_credit <= 1'b0;
      tx_count  <= '0;
      rx_count  <= '0;
      err       <= '0;
    end else begin
      inj_valid <= send;
      ej_credit <= ej_pop;
      if (send) begin
        inj_data <= inj_dout;
        tx_count <= tx_count + CNT_W'(1);
      end
      if (bus.rt_inj_credit && credits == CREDIT_MAX)
        err[ERR_CREDIT_OVF] <= 1'b1;
      else if (bus.rt_inj_credit && !send)
        credits <= credits + CW'(1);
      else if (!bus.rt_inj_credit && send)
        credits <= credits - CW'(1);
      if (ej_accept)
        rx_count <= rx_count + CNT_W'(1);
      if (bus.rt_ej_valid && !ej_accept)
        err[ERR_EJ_OVF] <= 1'b1;
    end
  end

endmodule
